// File: rtl/fitness_arbiter_if.sv
// Handshake bundle between the GA engines, the fitness arbiter and the shared evaluator.
// The arbiter connects through the master modport; engines and evaluator use the slave modport.
interface fitness_arbiter_if #(
    parameter int ErrorWidth      = 32,
    parameter int IndividualWidth = 32,
    parameter int Requesters      = 4
);
    logic [Requesters-1:0]                 req_start;
    logic [Requesters*IndividualWidth-1:0] req_individual;
    logic [Requesters-1:0]                 req_finish;
    logic [ErrorWidth-1:0]                 req_error;
    logic                                  eval_start;
    logic [IndividualWidth-1:0]            eval_individual;
    logic                                  eval_finish;
    logic [ErrorWidth-1:0]                 eval_error;
    logic                                  eval_abort;
    logic [Requesters-1:0]                 grant;
    logic                                  busy;
    logic                                  timed_out;

    modport master (
        input  req_start,
        input  req_individual,
        input  eval_finish,
        input  eval_error,
        output req_finish,
        output req_error,
        output eval_start,
        output eval_individual,
        output eval_abort,
        output grant,
        output busy,
        output timed_out
    );

    modport slave (
        output req_start,
        output req_individual,
        output eval_finish,
        output eval_error,
        input  req_finish,
        input  req_error,
        input  eval_start,
        input  eval_individual,
        input  eval_abort,
        input  grant,
        input  busy,
        input  timed_out
    );
endinterface

// File: rtl/fitness_arbiter.sv
// Round-robin arbiter sharing one fitness evaluator between several GA engines,
// with a watchdog that releases the evaluator when it never finishes.
module fitness_arbiter #(
    parameter int ErrorWidth      = 32,
    parameter int IndividualWidth = 32,
    parameter int Requesters      = 4,
    parameter int TimeoutWidth    = 16,
    parameter int TimeoutCycles   = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    fitness_arbiter_if.master bus
);

    localparam int IdxWidth = (Requesters > 1) ? $clog2(Requesters) : 1;
    localparam logic [IdxWidth-1:0]     LastIdx     = IdxWidth'(Requesters - 1);
    localparam logic [TimeoutWidth-1:0] CountOne    = TimeoutWidth'(1);
    localparam logic [TimeoutWidth-1:0] CountMax    = {TimeoutWidth{1'b1}};
    localparam logic [TimeoutWidth-1:0] CountExpire = TimeoutWidth'(TimeoutCycles - 1);
    localparam logic                    WatchdogOn  = (TimeoutCycles != 0);
    localparam logic [Requesters-1:0]   OneHotBase  = {{(Requesters-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_RESPOND = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t                     r_state;
    logic [Requesters-1:0]      r_grant;
    logic [IdxWidth-1:0]        r_grant_idx;
    logic [IdxWidth-1:0]        r_last_grant;
    logic [Requesters-1:0]      r_served;
    logic [TimeoutWidth-1:0]    r_count;
    logic [IndividualWidth-1:0] r_eval_individual;
    logic [ErrorWidth-1:0]      r_req_error;
    logic [Requesters-1:0]      r_req_finish;
    logic                       r_eval_start;
    logic                       r_eval_abort;
    logic                       r_timed_out;
    logic                       r_busy;

    logic [Requesters-1:0]      w_eligible;
    logic                       w_found;
    logic [IdxWidth-1:0]        w_win_idx;
    logic [IdxWidth-1:0]        w_cand_idx;
    int                         w_cand;
    logic [Requesters-1:0]      w_win_onehot;
    logic [IndividualWidth-1:0] w_win_individual;
    logic [Requesters-1:0]      w_served_set;

    // Round-robin search: first eligible requester after the previous grantee.
    always_comb begin
        w_eligible = bus.req_start & ~r_served;
        w_found    = 1'b0;
        w_win_idx  = {IdxWidth{1'b0}};
        w_cand     = 0;
        w_cand_idx = {IdxWidth{1'b0}};
        for (int off = 1; off <= Requesters; off++) begin
            w_cand     = (int'(r_last_grant) + off) % Requesters;
            w_cand_idx = IdxWidth'(w_cand);
            if (!w_found && w_eligible[w_cand_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand_idx;
            end else begin
                w_found   = w_found;
            end
        end
    end

    // Decode the winner into its one-hot grant and its individual slice.
    always_comb begin
        w_win_onehot     = OneHotBase << w_win_idx;
        w_win_individual = {IndividualWidth{1'b0}};
        for (int i = 0; i < Requesters; i++) begin
            if (w_win_idx == IdxWidth'(i)) begin
                w_win_individual = bus.req_individual[i*IndividualWidth +: IndividualWidth];
            end else begin
                w_win_individual = w_win_individual;
            end
        end
    end

    // A grantee is marked served as its response goes out; a low request forgets it.
    assign w_served_set = (r_state == S_RESPOND) ? r_grant : {Requesters{1'b0}};

    // Job sequencer: arbitration, issue, watchdog, response and finish drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_grant           <= {Requesters{1'b0}};
            r_grant_idx       <= {IdxWidth{1'b0}};
            r_last_grant      <= LastIdx;
            r_served          <= {Requesters{1'b0}};
            r_count           <= {TimeoutWidth{1'b0}};
            r_eval_individual <= {IndividualWidth{1'b0}};
            r_req_error       <= {ErrorWidth{1'b0}};
            r_req_finish      <= {Requesters{1'b0}};
            r_eval_start      <= 1'b0;
            r_eval_abort      <= 1'b0;
            r_timed_out       <= 1'b0;
            r_busy            <= 1'b0;
        end else begin
            r_eval_start <= 1'b0;
            r_eval_abort <= 1'b0;
            r_timed_out  <= 1'b0;
            r_req_finish <= {Requesters{1'b0}};
            r_served     <= (r_served | w_served_set) & bus.req_start;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state           <= S_ISSUE;
                        r_grant           <= w_win_onehot;
                        r_grant_idx       <= w_win_idx;
                        r_eval_individual <= w_win_individual;
                        r_eval_start      <= 1'b1;
                        r_busy            <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    r_count <= {TimeoutWidth{1'b0}};
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.eval_finish) begin
                        r_req_error  <= bus.eval_error;
                        r_req_finish <= r_grant;
                        r_state      <= S_RESPOND;
                    end else if (WatchdogOn && (r_count == CountExpire)) begin
                        // Abort: the engine sees a worst-case (all-ones) error.
                        r_req_error  <= {ErrorWidth{1'b1}};
                        r_req_finish <= r_grant;
                        r_timed_out  <= 1'b1;
                        r_eval_abort <= 1'b1;
                        r_state      <= S_RESPOND;
                    end else if (r_count != CountMax) begin
                        r_count <= r_count + CountOne;
                    end else begin
                        r_count <= r_count;
                    end
                end

                S_RESPOND: begin
                    r_last_grant <= r_grant_idx;
                    r_grant      <= {Requesters{1'b0}};
                    r_state      <= S_DRAIN;
                end

                S_DRAIN: begin
                    // A stretched finish must not complete the next job.
                    if (bus.eval_finish) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_grant <= {Requesters{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant           = r_grant;
    assign bus.busy            = r_busy;
    assign bus.eval_start      = r_eval_start;
    assign bus.eval_individual = r_eval_individual;
    assign bus.eval_abort      = r_eval_abort;
    assign bus.req_finish      = r_req_finish;
    assign bus.req_error       = r_req_error;
    assign bus.timed_out       = r_timed_out;

endmodule

// File: tb/tb_fitness_arbiter.sv
// Self-checking bench for fitness_arbiter: directed scenarios followed by
// randomized jobs, all checked against a job-level model of the arbitration rules.
module tb_fitness_arbiter;

    localparam int EW = 32;
    localparam int IW = 32;
    localparam int NR = 4;
    localparam int TW = 16;
    localparam int TC = 8;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    int fin_count;
    int fin_before;
    int won;
    int first_won;

    logic [NR-1:0] m_served;
    int            m_last;
    logic [IW-1:0] m_ind [NR];

    fitness_arbiter_if #(.ErrorWidth(EW), .IndividualWidth(IW), .Requesters(NR)) bus ();

    fitness_arbiter #(
        .ErrorWidth     (EW),
        .IndividualWidth(IW),
        .Requesters     (NR),
        .TimeoutWidth   (TW),
        .TimeoutCycles  (TC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next owner under the rules: first requester after the last owner that is requesting and unserved.
    function automatic int predict_winner(input logic [NR-1:0] start, input logic [NR-1:0] served,
                                          input int last);
        for (int off = 1; off <= NR; off++) begin
            int c;
            c = (last + off) % NR;
            if (start[c] && !served[c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        for (int i = 0; i < NR; i++) begin
            if (!bus.req_start[i]) m_served[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        if (bus.req_finish != '0) fin_count++;
    endtask

    task automatic set_ind(input int i, input logic [IW-1:0] v);
        m_ind[i] = v;
        bus.req_individual[i*IW +: IW] = v;
    endtask

    task automatic do_reset();
        bus.req_start   = '0;
        bus.eval_finish = 1'b0;
        bus.eval_error  = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_served = '0;
        m_last   = NR - 1;
    endtask

    // One job starting from an IDLE cycle; finish in cycle 1+k unless silent; finish held stretch extra cycles.
    task automatic run_job(input int k, input bit silent, input int stretch, input logic [EW-1:0] err,
                           input logic [NR-1:0] drain_mask, output int w);
        logic [NR-1:0] g1;
        int cur;
        w = predict_winner(bus.req_start, m_served, m_last);
        step();
        if (w < 0) begin
            check("idle_grant", bus.grant, '0);
            check("idle_busy", bus.busy, 1'b0);
            check("idle_start", bus.eval_start, 1'b0);
            return;
        end
        g1 = '0;
        g1[w] = 1'b1;
        check("issue_start", bus.eval_start, 1'b1);
        check("issue_grant", bus.grant, g1);
        check("issue_ind", bus.eval_individual, m_ind[w]);
        check("issue_busy", bus.busy, 1'b1);
        for (int c = 2; c <= 1 + k; c++) begin
            step();
            check("wait_start", bus.eval_start, 1'b0);
            check("wait_fin", bus.req_finish, '0);
            check("wait_grant", bus.grant, g1);
            check("wait_ind", bus.eval_individual, m_ind[w]);
            if (c == 1 + k && !silent) begin
                bus.eval_finish = 1'b1;
                bus.eval_error  = err;
            end
        end
        step();
        check("resp_fin", bus.req_finish, g1);
        check("resp_err", bus.req_error, silent ? {EW{1'b1}} : err);
        check("resp_timeout", bus.timed_out, silent);
        check("resp_abort", bus.eval_abort, silent);
        check("resp_grant", bus.grant, g1);
        if (stretch == 0) bus.eval_finish = 1'b0;
        if (bus.req_start[w]) m_served[w] = 1'b1;
        m_last = w;
        step();
        cur = 3 + k;
        check("drain_fin", bus.req_finish, '0);
        check("drain_grant", bus.grant, '0);
        check("drain_busy", bus.busy, 1'b1);
        bus.req_start = drain_mask;
        if (cur >= 2 + k + stretch) bus.eval_finish = 1'b0;
        while (bus.eval_finish) begin
            step();
            cur++;
            check("stretch_start", bus.eval_start, 1'b0);
            check("stretch_fin", bus.req_finish, '0);
            check("stretch_busy", bus.busy, 1'b1);
            if (cur >= 2 + k + stretch) bus.eval_finish = 1'b0;
        end
        step();
        check("back_idle", bus.busy, 1'b0);
    endtask

    initial begin
        logic [31:0] rnd;
        bit silent;
        int k;
        int stretch;

        checks = 0;
        errors = 0;
        fin_count = 0;
        rst_n = 1'b1;
        bus.req_start      = '0;
        bus.req_individual = '0;
        bus.eval_finish    = 1'b0;
        bus.eval_error     = '0;
        m_served = '0;
        m_last   = NR - 1;
        for (int i = 0; i < NR; i++) m_ind[i] = '0;

        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_grant", bus.grant, '0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_start", bus.eval_start, 1'b0);
        check("rst_ind", bus.eval_individual, '0);
        check("rst_fin", bus.req_finish, '0);
        check("rst_err", bus.req_error, '0);
        check("rst_abort", bus.eval_abort, 1'b0);
        check("rst_timeout", bus.timed_out, 1'b0);
        do_reset();

        // Single request: 0x12345678 in, 0xF back after 5 cycles.
        set_ind(0, 32'h1234_5678);
        bus.req_start = 4'b0001;
        run_job(5, 1'b0, 0, 32'h0000_000F, 4'b0000, won);
        check("single_winner", won, 0);

        // Fairness: all four held, finished one toggled low for a cycle.
        do_reset();
        for (int i = 0; i < NR; i++) set_ind(i, 32'hA000_0000 + i);
        for (int j = 0; j < 6; j++) begin
            rnd = 32'hF & ~(32'h1 << (j % NR));
            bus.req_start = 4'b1111;
            run_job(j % 3 + 1, 1'b0, 0, 32'h100 + j, rnd[NR-1:0], won);
            check("rr_order", won, j % NR);
        end

        // Held request is not served again until it drops.
        bus.req_start = 4'b0100;
        run_job(2, 1'b0, 0, 32'h55, 4'b0100, won);
        check("held_first", won, 2);
        run_job(2, 1'b0, 0, 32'h66, 4'b0100, first_won);
        check("held_block", first_won, -1);
        run_job(2, 1'b0, 0, 32'h66, 4'b0100, first_won);
        check("held_block2", first_won, -1);
        bus.req_start = 4'b0000;
        step();
        bus.req_start = 4'b0100;
        run_job(3, 1'b0, 0, 32'h77, 4'b0000, won);
        check("held_regrant", won, 2);

        // Watchdog with a silent evaluator.
        bus.req_start = 4'b0001;
        run_job(TC, 1'b1, 0, 32'h0, 4'b0000, won);
        check("wd_winner", won, 0);

        // Stretched finish with a second request pending.
        set_ind(1, 32'hBEEF_0001);
        bus.req_start = 4'b0011;
        fin_before = fin_count;
        run_job(2, 1'b0, 4, 32'hCAFE, 4'b0011, won);
        check("stretch_winner", won, 1);
        check("stretch_one_fin", fin_count - fin_before, 1);
        run_job(1, 1'b0, 0, 32'hD00D, 4'b0000, won);
        check("stretch_next", won, 0);

        // Randomized jobs.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++) set_ind(i, $urandom());
            rnd = $urandom_range(0, 15);
            bus.req_start = rnd[NR-1:0];
            silent  = ($urandom_range(0, 4) == 0);
            k       = silent ? TC : $urandom_range(1, TC);
            stretch = silent ? 0 : $urandom_range(0, 3);
            rnd = $urandom_range(0, 15);
            run_job(k, silent, stretch, $urandom(), rnd[NR-1:0], won);
        end

        // Reset in the middle of WAIT.
        set_ind(1, 32'h0BAD_F00D);
        bus.req_start = 4'b0010;
        won = predict_winner(bus.req_start, m_served, m_last);
        step();
        check("mid_issue", bus.eval_start, 1'b1);
        step();
        step();
        fin_before = fin_count;
        #2;
        rst_n = 1'b0;
        bus.req_start = '0;
        #1;
        check("mid_rst_grant", bus.grant, '0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_ind", bus.eval_individual, '0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_served = '0;
        m_last   = NR - 1;
        repeat (4) step();
        check("mid_rst_no_fin", fin_count - fin_before, 0);
        check("mid_rst_idle", bus.busy, 1'b0);
        bus.req_start = 4'b0010;
        run_job(2, 1'b0, 0, 32'h1357, 4'b0000, won);
        check("mid_rst_rehandshake", won, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
